// File: rtl/fifo_buffer_flags.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/almost-empty
// thresholds, overflow/underflow pulses and optional first-word-fall-through.
module fifo_buffer_flags #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = 12,
    parameter int unsigned AE_LEVEL = 4,
    parameter bit          FWFT     = 1'b0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write_en,
    input  logic                     read_en,
    input  logic [WIDTH-1:0]         data_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_empty,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Out-of-range configuration is reported once the clock runs
    if (WIDTH < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        AF_LEVEL < 1 || AF_LEVEL > DEPTH || AE_LEVEL >= DEPTH) begin : g_cfg_err
        always @(posedge clk) begin
            $error("fifo_buffer_flags: illegal parameter set");
        end
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
    logic [CNT_W-1:0] count_next;
    logic [WIDTH-1:0] data_out_next;
    logic             wr_acc, rd_acc;

    // Accept decisions and next-state arithmetic on pre-edge state
    always_comb begin
        rd_acc      = read_en & ~empty;
        wr_acc      = write_en & (~full | rd_acc);
        wr_ptr_next = wr_ptr + PTR_W'(wr_acc);
        rd_ptr_next = rd_ptr + PTR_W'(rd_acc);
        count_next  = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    end

    // Read data: popped word in standard mode, post-edge head in FWFT mode
    always_comb begin
        data_out_next = data_out;
        if (FWFT) begin
            if (count_next == '0) begin
                data_out_next = '0;
            end else if (wr_acc && (wr_ptr == rd_ptr_next)) begin
                // head is the word being written on this very edge
                data_out_next = data_in;
            end else begin
                data_out_next = mem[rd_ptr_next];
            end
        end else if (rd_acc) begin
            data_out_next = mem[rd_ptr];
        end
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers, count, flags and pulses; flags follow the registered count
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            data_out     <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            wr_ptr       <= wr_ptr_next;
            rd_ptr       <= rd_ptr_next;
            count        <= count_next;
            data_out     <= data_out_next;
            empty        <= (count_next == '0);
            full         <= (count_next == CNT_W'(DEPTH));
            almost_empty <= (count_next <= CNT_W'(AE_LEVEL));
            almost_full  <= (count_next >= CNT_W'(AF_LEVEL));
            overflow     <= write_en & ~wr_acc;
            underflow    <= read_en & empty;
        end
    end

endmodule

// File: tb/tb_fifo_buffer_flags.sv
// Bench for fifo_buffer_flags: standard and FWFT instances share stimulus and
// are checked against a queue-based reference model.
module tb_fifo_buffer_flags;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AF    = 12;
    localparam int unsigned AE    = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             write_en = 1'b0;
    logic             read_en = 1'b0;
    logic [WIDTH-1:0] data_in = '0;

    logic [WIDTH-1:0] d0_data_out, d1_data_out;
    logic             d0_empty, d0_full, d0_ae, d0_af, d0_ovf, d0_unf;
    logic             d1_empty, d1_full, d1_ae, d1_af, d1_ovf, d1_unf;
    logic [4:0]       d0_count, d1_count;

    always #5 clk = ~clk;

    fifo_buffer_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .write_en(write_en), .read_en(read_en), .data_in(data_in),
        .data_out(d0_data_out), .empty(d0_empty), .full(d0_full), .almost_empty(d0_ae),
        .almost_full(d0_af), .count(d0_count), .overflow(d0_ovf), .underflow(d0_unf));

    fifo_buffer_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1'b1)) dut1 (
        .clk(clk), .reset(reset), .write_en(write_en), .read_en(read_en), .data_in(data_in),
        .data_out(d1_data_out), .empty(d1_empty), .full(d1_full), .almost_empty(d1_ae),
        .almost_full(d1_af), .count(d1_count), .overflow(d1_ovf), .underflow(d1_unf));

    int tests = 0;
    int fails = 0;

    // Reference model: contents as a queue plus the last popped word
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_dout0 = '0;
    logic             exp_ovf = 1'b0;
    logic             exp_unf = 1'b0;

    typedef struct {
        logic       we;
        logic       re;
        logic [7:0] din;
        int         cnt;
        logic       ae;
        logic [7:0] dout;
        logic       unf;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        logic [WIDTH-1:0] head;
        n    = q.size();
        head = (n > 0) ? q[0] : '0;
        chk("std.count", 32'(d0_count), n);
        chk("std.empty", 32'(d0_empty), 32'(n == 0));
        chk("std.full",  32'(d0_full),  32'(n == DEPTH));
        chk("std.ae",    32'(d0_ae),    32'(n <= AE));
        chk("std.af",    32'(d0_af),    32'(n >= AF));
        chk("std.ovf",   32'(d0_ovf),   32'(exp_ovf));
        chk("std.unf",   32'(d0_unf),   32'(exp_unf));
        chk("std.dout",  32'(d0_data_out), 32'(exp_dout0));
        chk("fwft.count", 32'(d1_count), n);
        chk("fwft.empty", 32'(d1_empty), 32'(n == 0));
        chk("fwft.full",  32'(d1_full),  32'(n == DEPTH));
        chk("fwft.ae",    32'(d1_ae),    32'(n <= AE));
        chk("fwft.af",    32'(d1_af),    32'(n >= AF));
        chk("fwft.ovf",   32'(d1_ovf),   32'(exp_ovf));
        chk("fwft.unf",   32'(d1_unf),   32'(exp_unf));
        chk("fwft.dout",  32'(d1_data_out), 32'(head));
    endtask

    // One clock: drive inputs, advance the model at the edge, check on the falling edge
    task automatic step(input logic we, input logic re, input logic [WIDTH-1:0] din);
        bit rd_ok, wr_ok;
        write_en = we;
        read_en  = re;
        data_in  = din;
        @(posedge clk);
        rd_ok   = re && (q.size() > 0);
        wr_ok   = we && ((q.size() < DEPTH) || rd_ok);
        exp_ovf = we && !wr_ok;
        exp_unf = re && (q.size() == 0);
        if (rd_ok) exp_dout0 = q.pop_front();
        if (wr_ok) q.push_back(din);
        @(negedge clk);
        write_en = 1'b0;
        read_en  = 1'b0;
        check_all();
    endtask

    task automatic model_reset();
        q.delete();
        exp_dout0 = '0;
        exp_ovf   = 1'b0;
        exp_unf   = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        write_en = 1'b0;
        read_en  = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        check_all();
        reset = 1'b1;
    endtask

    initial begin
        tbl[0] = '{1'b0, 1'b1, 8'h00, 0, 1'b1, 8'h00, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 8'hA1, 1, 1'b1, 8'h00, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 8'hB2, 2, 1'b1, 8'h00, 1'b0};
        tbl[3] = '{1'b1, 1'b0, 8'hC3, 3, 1'b1, 8'h00, 1'b0};
        tbl[4] = '{1'b1, 1'b0, 8'hD4, 4, 1'b1, 8'h00, 1'b0};
        tbl[5] = '{1'b1, 1'b0, 8'hE5, 5, 1'b0, 8'h00, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 8'h00, 4, 1'b1, 8'hA1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 8'h00, 3, 1'b1, 8'hB2, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 8'h00, 2, 1'b1, 8'hC3, 1'b0};

        do_reset();

        // Reset/fill/read table
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].we, tbl[i].re, tbl[i].din);
            chk("tbl.count", 32'(d0_count), tbl[i].cnt);
            chk("tbl.ae",    32'(d0_ae),    32'(tbl[i].ae));
            chk("tbl.dout",  32'(d0_data_out), 32'(tbl[i].dout));
            chk("tbl.unf",   32'(d0_unf),   32'(tbl[i].unf));
        end

        // Fill to full, then one dropped write
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'(i));
            if (i == 10) chk("fill.af_before", 32'(d0_af), 0);
            if (i == 11) chk("fill.af_at12", 32'(d0_af), 1);
        end
        chk("fill.full", 32'(d0_full), 1);
        chk("fill.count", 32'(d0_count), 16);
        step(1'b1, 1'b0, 8'hFF);
        chk("ovf.pulse", 32'(d0_ovf), 1);
        chk("ovf.count", 32'(d0_count), 16);
        step(1'b0, 1'b0, 8'h00);
        chk("ovf.clear", 32'(d0_ovf), 0);

        // Drain in order, then a rejected read
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("drain.data", 32'(d0_data_out), i);
        end
        chk("drain.empty", 32'(d0_empty), 1);
        step(1'b0, 1'b1, 8'h00);
        chk("unf.pulse", 32'(d0_unf), 1);
        chk("unf.hold", 32'(d0_data_out), 32'h0F);

        // Write+read at empty: write taken, read rejected
        step(1'b1, 1'b1, 8'h66);
        chk("sim_empty.unf", 32'(d0_unf), 1);
        chk("sim_empty.count", 32'(d0_count), 1);
        step(1'b0, 1'b1, 8'h00);
        chk("sim_empty.read", 32'(d0_data_out), 32'h66);

        // Write+read at full: both taken, new word last out
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
        step(1'b1, 1'b1, 8'h55);
        chk("sim_full.count", 32'(d0_count), 16);
        chk("sim_full.ovf", 32'(d0_ovf), 0);
        chk("sim_full.pop", 32'(d0_data_out), 32'h20);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h00);
        chk("sim_full.last", 32'(d0_data_out), 32'h55);

        // FWFT head visibility
        do_reset();
        step(1'b1, 1'b0, 8'h3C);
        chk("fwft.first", 32'(d1_data_out), 32'h3C);
        step(1'b1, 1'b0, 8'h4D);
        step(1'b0, 1'b1, 8'h00);
        chk("fwft.next", 32'(d1_data_out), 32'h4D);
        step(1'b0, 1'b1, 8'h00);
        chk("fwft.zero", 32'(d1_data_out), 0);

        // Randomised phases alternating fill-heavy and drain-heavy traffic
        for (int p = 0; p < 12; p++) begin
            int wp;
            wp = (p % 2 == 0) ? 75 : 30;
            for (int i = 0; i < 150; i++) begin
                step($urandom_range(99) < wp, $urandom_range(99) < (100 - wp + 5), 8'($urandom));
            end
        end

        // Async reset between edges with 7 words stored
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'h70 + i));
        chk("areset.pre", 32'(d0_count), 7);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        reset = 1'b1;
        step(1'b1, 1'b0, 8'h11);
        chk("areset.fwft", 32'(d1_data_out), 32'h11);
        step(1'b0, 1'b1, 8'h00);
        chk("areset.read", 32'(d0_data_out), 32'h11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
